// File: rtl/decode_pkg.sv
// Shared decode definitions: uop layout, ALU opcodes, instruction opcode/funct encodings.
package decode_pkg;

    localparam int ALUOP_W = 9;
    localparam int UOP_W   = ALUOP_W + 1 + 1 + 5 + 5 + 5 + 32;

    localparam int IMM_LSB       = 0;
    localparam int RDST_LSB      = 32;
    localparam int SRC2_LSB      = 37;
    localparam int SRC1_LSB      = 42;
    localparam int INSTVALID_BIT = 47;
    localparam int REGW_BIT      = 48;
    localparam int ALUOP_LSB     = 49;

    localparam logic [ALUOP_W-1:0] ALU_ADD   = 9'h001;
    localparam logic [ALUOP_W-1:0] ALU_SUB   = 9'h002;
    localparam logic [ALUOP_W-1:0] ALU_AND   = 9'h004;
    localparam logic [ALUOP_W-1:0] ALU_OR    = 9'h008;
    localparam logic [ALUOP_W-1:0] ALU_XOR   = 9'h010;
    localparam logic [ALUOP_W-1:0] ALU_SLT   = 9'h020;
    localparam logic [ALUOP_W-1:0] ALU_LUI   = 9'h040;
    localparam logic [ALUOP_W-1:0] ALU_LOAD  = 9'h080;
    localparam logic [ALUOP_W-1:0] ALU_STORE = 9'h100;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_OR  = 6'h25;
    localparam logic [5:0] F_XOR = 6'h26;
    localparam logic [5:0] F_SLT = 6'h2A;

    typedef struct packed {
        logic [ALUOP_W-1:0] aluop;
        logic               regw;
        logic               instvalid;
        logic [4:0]         src1;
        logic [4:0]         src2;
        logic [4:0]         rdst;
        logic [31:0]        imm;
    } uop_t;

    function automatic logic [31:0] sign_ext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

    function automatic logic [31:0] zero_ext16(input logic [15:0] v);
        return {16'h0000, v};
    endfunction

endpackage

// File: rtl/decode_slot.sv
// Combinational decode of one 32-bit instruction into a uop; unknown encodings decode to all-zero.
module decode_slot
    import decode_pkg::*;
(
    input  logic [31:0] inst,
    output uop_t        uop
);

    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm16;

    assign opcode = inst[31:26];
    assign rs     = inst[25:21];
    assign rt     = inst[20:16];
    assign rd     = inst[15:11];
    assign shamt  = inst[10:6];
    assign funct  = inst[5:0];
    assign imm16  = inst[15:0];

    always_comb begin
        uop = '0;
        case (opcode)
            OP_RTYPE: begin
                uop.src1      = rs;
                uop.src2      = rt;
                uop.rdst      = rd;
                uop.regw      = 1'b1;
                uop.instvalid = (shamt == 5'd0);
                case (funct)
                    F_ADD:   uop.aluop = ALU_ADD;
                    F_SUB:   uop.aluop = ALU_SUB;
                    F_AND:   uop.aluop = ALU_AND;
                    F_OR:    uop.aluop = ALU_OR;
                    F_XOR:   uop.aluop = ALU_XOR;
                    F_SLT:   uop.aluop = ALU_SLT;
                    default: uop.instvalid = 1'b0;
                endcase
            end
            OP_ADDI, OP_SLTI, OP_LW: begin
                uop.aluop     = (opcode == OP_ADDI) ? ALU_ADD :
                                (opcode == OP_SLTI) ? ALU_SLT : ALU_LOAD;
                uop.src1      = rs;
                uop.rdst      = rt;
                uop.imm       = sign_ext16(imm16);
                uop.regw      = 1'b1;
                uop.instvalid = 1'b1;
            end
            OP_ANDI, OP_ORI, OP_XORI: begin
                uop.aluop     = (opcode == OP_ANDI) ? ALU_AND :
                                (opcode == OP_ORI)  ? ALU_OR  : ALU_XOR;
                uop.src1      = rs;
                uop.rdst      = rt;
                uop.imm       = zero_ext16(imm16);
                uop.regw      = 1'b1;
                uop.instvalid = 1'b1;
            end
            OP_LUI: begin
                uop.aluop     = ALU_LUI;
                uop.rdst      = rt;
                uop.imm       = {imm16, 16'h0000};
                uop.regw      = 1'b1;
                uop.instvalid = 1'b1;
            end
            // Stores and branches read both registers and write none.
            OP_SW, OP_BEQ: begin
                uop.aluop     = (opcode == OP_SW) ? ALU_STORE : ALU_SUB;
                uop.src1      = rs;
                uop.src2      = rt;
                uop.imm       = sign_ext16(imm16);
                uop.instvalid = 1'b1;
            end
            default: ;
        endcase
        if (!uop.instvalid)
            uop = '0;
    end

endmodule

// File: rtl/decode_queue.sv
// ISSUE_W-wide decode stage feeding a DEPTH-entry bundle FIFO with flush.
// Optional intra-bundle RAW hazard flags are built when DEC_HAZARD_EN is defined.
module decode_queue
    import decode_pkg::*;
#(
    parameter int ISSUE_W = 2,
    parameter int DEPTH   = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [ISSUE_W-1:0]          in_lane_v,
    input  logic [32*ISSUE_W-1:0]       in_inst,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [ISSUE_W-1:0]          out_lane_v,
    output logic [UOP_W*ISSUE_W-1:0]    out_uop,
    output logic [ISSUE_W-1:0]          out_hazard,
    output logic [$clog2(DEPTH+1)-1:0]  occupancy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int BUS_W = UOP_W * ISSUE_W;

    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push, pop;

    uop_t             dec_uop  [ISSUE_W];
    uop_t             slot_uop [ISSUE_W];
    logic [BUS_W-1:0] wr_bus;
    logic [BUS_W-1:0]   uop_mem  [DEPTH];
    logic [ISSUE_W-1:0] lane_mem [DEPTH];

    for (genvar g = 0; g < ISSUE_W; g++) begin : g_slot
        decode_slot u_slot (
            .inst (in_inst[32*g +: 32]),
            .uop  (dec_uop[g])
        );
    end

    always_comb begin
        wr_bus = '0;
        for (int i = 0; i < ISSUE_W; i++) begin
            slot_uop[i] = in_lane_v[i] ? dec_uop[i] : '0;
            wr_bus[UOP_W*i +: UOP_W] = slot_uop[i];
        end
    end

    // Handshake: a bundle moves when valid and ready are both high at a rising edge.
    // in_ready depends only on fullness, never on out_ready; flush overrides both sides.
    assign in_ready  = (count < CNT_W'(DEPTH)) & rst_n;
    assign out_valid = (count != '0) & rst_n;
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;
    assign occupancy = count;

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            uop_mem[wr_ptr]  <= wr_bus;
            lane_mem[wr_ptr] <= in_lane_v;
        end
    end

    assign out_uop    = out_valid ? uop_mem[rd_ptr]  : '0;
    assign out_lane_v = out_valid ? lane_mem[rd_ptr] : '0;

`ifdef DEC_HAZARD_EN
    logic [ISSUE_W-1:0] haz_in;
    logic [ISSUE_W-1:0] haz_mem [DEPTH];

    // Invalid lanes were zeroed above, so they never produce or trigger a hazard.
    always_comb begin
        haz_in = '0;
        for (int i = 1; i < ISSUE_W; i++) begin
            for (int j = 0; j < i; j++) begin
                if (slot_uop[j].regw && (slot_uop[j].rdst != 5'd0) &&
                    ((slot_uop[i].src1 == slot_uop[j].rdst) ||
                     (slot_uop[i].src2 == slot_uop[j].rdst)))
                    haz_in[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            haz_mem[wr_ptr] <= haz_in;
    end

    assign out_hazard = out_valid ? haz_mem[rd_ptr] : '0;
`else
    assign out_hazard = '0;
`endif

endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue (ISSUE_W=2, DEPTH=4); follows DEC_HAZARD_EN if defined.
module tb_decode_queue;
  import decode_pkg::*;

  localparam int ISSUE_W = 2;
  localparam int DEPTH   = 4;

  logic                       clk = 1'b0;
  logic                       rst_n;
  logic                       flush;
  logic                       in_valid;
  logic                       in_ready;
  logic [ISSUE_W-1:0]         in_lane_v;
  logic [32*ISSUE_W-1:0]      in_inst;
  logic                       out_valid;
  logic                       out_ready;
  logic [ISSUE_W-1:0]         out_lane_v;
  logic [UOP_W*ISSUE_W-1:0]   out_uop;
  logic [ISSUE_W-1:0]         out_hazard;
  logic [$clog2(DEPTH+1)-1:0] occupancy;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  decode_queue #(.ISSUE_W(ISSUE_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_lane_v(in_lane_v), .in_inst(in_inst),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_lane_v(out_lane_v), .out_uop(out_uop),
    .out_hazard(out_hazard), .occupancy(occupancy)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic uop_t slot(input int i);
    return uop_t'(out_uop[UOP_W*i +: UOP_W]);
  endfunction

  function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] mk_r(input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [4:0] rd, input logic [5:0] funct);
    return {OP_RTYPE, rs, rt, rd, 5'd0, funct};
  endfunction

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] lv, input logic [31:0] i0, input logic [31:0] i1);
    in_valid  = 1'b1;
    in_lane_v = lv;
    in_inst   = {i1, i0};
  endtask

  task automatic push_tag(input logic [15:0] tag);
    drive(2'b11, mk_i(OP_ADDI, 5'd0, 5'd1, tag), mk_i(OP_ADDI, 5'd0, 5'd2, tag));
    step();
    in_valid = 1'b0;
    exp_q.push_back(32'(tag));
  endtask

  task automatic pop_check(input string tag);
    logic [31:0] e;
    e = exp_q.pop_front();
    check({tag, "_head"}, 64'(slot(0).imm), 64'(e));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    uop_t u;
    logic [63:0] exp_haz;

    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drive(2'b11, mk_i(OP_ADDI, 5'd1, 5'd3, 16'h0001), mk_i(OP_ADDI, 5'd1, 5'd4, 16'h0002));

    // 1: reset with in_valid held high
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_in_ready", 64'(in_ready), 64'd0);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_occupancy", 64'(occupancy), 64'd0);
    end
    rst_n = 1'b1; in_valid = 1'b0;
    step();
    check("rel_in_ready", 64'(in_ready), 64'd1);
    check("rel_occupancy", 64'(occupancy), 64'd0);

    // 2: addi r3,r1,-4 / add r5,r3,r2
    drive(2'b11, mk_i(OP_ADDI, 5'd1, 5'd3, 16'hFFFC), mk_r(5'd3, 5'd2, 5'd5, F_ADD));
    step();
    in_valid = 1'b0;
    check("t2_out_valid", 64'(out_valid), 64'd1);
    check("t2_occupancy", 64'(occupancy), 64'd1);
    u = slot(0);
    check("t2_s0_imm", 64'(u.imm), 64'hFFFF_FFFC);
    check("t2_s0_rdst", 64'(u.rdst), 64'd3);
    check("t2_s0_regw", 64'(u.regw), 64'd1);
    check("t2_s0_word", 64'(u), 64'({ALU_ADD, 1'b1, 1'b1, 5'd1, 5'd0, 5'd3, 32'hFFFF_FFFC}));
    u = slot(1);
    check("t2_s1_src1", 64'(u.src1), 64'd3);
    check("t2_s1_src1_fld", 64'(out_uop[UOP_W + SRC1_LSB +: 5]), 64'd3);
    check("t2_s1_word", 64'(u), 64'({ALU_ADD, 1'b1, 1'b1, 5'd3, 5'd2, 5'd5, 32'h0}));
`ifdef DEC_HAZARD_EN
    exp_haz = 64'd2;
`else
    exp_haz = 64'd0;
`endif
    check("t2_hazard", 64'(out_hazard), exp_haz);
    check("t2_lane_v", 64'(out_lane_v), 64'd3);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("t2_pop_valid", 64'(out_valid), 64'd0);
    check("t2_pop_uop_gated", 64'(out_uop), 64'd0);
    check("t2_pop_lane_gated", 64'(out_lane_v), 64'd0);

    // 3: fill, reject when full, pop while full
    for (int t = 1; t <= 4; t++) push_tag(16'(t));
    check("t3_full_occ", 64'(occupancy), 64'd4);
    check("t3_full_in_ready", 64'(in_ready), 64'd0);
    drive(2'b11, mk_i(OP_ADDI, 5'd0, 5'd1, 16'd5), mk_i(OP_ADDI, 5'd0, 5'd2, 16'd5));
    step();
    check("t3_reject_occ", 64'(occupancy), 64'd4);
    out_ready = 1'b1;
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    void'(exp_q.pop_front());
    check("t3_popfull_occ", 64'(occupancy), 64'd3);
    pop_check("t3_drain0");
    pop_check("t3_drain1");
    pop_check("t3_drain2");
    check("t3_empty_occ", 64'(occupancy), 64'd0);
    check("t3_empty_valid", 64'(out_valid), 64'd0);

    // 4: streaming across pointer wrap
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive(2'b11, mk_i(OP_ADDI, 5'd0, 5'd1, 16'(100 + i)), mk_i(OP_ADDI, 5'd0, 5'd2, 16'(100 + i)));
      if (i > 0) begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check("t4_head", 64'(slot(0).imm), 64'(e));
        check("t4_valid", 64'(out_valid), 64'd1);
      end
      exp_q.push_back(32'(100 + i));
      step();
      check("t4_occ", 64'(occupancy), 64'd1);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    pop_check("t4_last");
    check("t4_end_occ", 64'(occupancy), 64'd0);

    // 5: flush with a same-cycle push
    push_tag(16'd200);
    push_tag(16'd201);
    push_tag(16'd202);
    check("t5_occ3", 64'(occupancy), 64'd3);
    drive(2'b11, mk_i(OP_ADDI, 5'd0, 5'd1, 16'd299), mk_i(OP_ADDI, 5'd0, 5'd2, 16'd299));
    flush = 1'b1; out_ready = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    exp_q.delete();
    check("t5_flush_occ", 64'(occupancy), 64'd0);
    check("t5_flush_valid", 64'(out_valid), 64'd0);
    check("t5_flush_uop", 64'(out_uop), 64'd0);
    step();
    check("t5_after_valid", 64'(out_valid), 64'd0);
    push_tag(16'd210);
    check("t5_repush_occ", 64'(occupancy), 64'd1);
    pop_check("t5_repush");

    // 6: lane mask, undefined opcode, zero-extension and LUI
    drive(2'b01, {6'h3F, 26'h0123456}, 32'hDEAD_BEEF);
    step();
    in_valid = 1'b0;
    check("t6_lane_v", 64'(out_lane_v), 64'd1);
    check("t6_s1_zero", 64'(slot(1)), 64'd0);
    check("t6_s0_instvalid", 64'(out_uop[INSTVALID_BIT]), 64'd0);
    check("t6_s0_regw", 64'(out_uop[REGW_BIT]), 64'd0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    drive(2'b11, mk_i(OP_ORI, 5'd2, 5'd4, 16'h8001), mk_i(OP_LUI, 5'd0, 5'd6, 16'h1234));
    step();
    in_valid = 1'b0;
    check("t6_ori_imm", 64'(out_uop[IMM_LSB +: 32]), 64'h0000_8001);
    check("t6_ori_aluop", 64'(out_uop[ALUOP_LSB +: ALUOP_W]), 64'(ALU_OR));
    check("t6_lui_imm", 64'(slot(1).imm), 64'h1234_0000);
    check("t6_lui_rdst", 64'(out_uop[UOP_W + RDST_LSB +: 5]), 64'd6);
    check("t6_lui_src2", 64'(out_uop[UOP_W + SRC2_LSB +: 5]), 64'd0);
    check("t6_no_hazard", 64'(out_hazard), 64'd0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("t6_end_occ", 64'(occupancy), 64'd0);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
